// File: rtl/q_sys_pll_reset_sequencer.sv
// PLL powerdown / MCGB reset sequencer with qualified lock fan-out.
// Define PLL_SEQ_RETRY_EN to retry on lock timeout instead of latching a fault.
module q_sys_pll_reset_sequencer #(
    parameter int unsigned PD_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 32,
    parameter int unsigned MCGB_DELAY         = 8,
    parameter int unsigned LOCK_TIMEOUT       = 4096,
    parameter int unsigned CNT_W              = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       pll_powerdown_a,
    input  logic       pll_powerdown_b,
    output logic       pll_powerdown,
    output logic       mcgb_rst,
    output logic       pll_locked_output,
    output logic       pll_locked_a,
    output logic       pll_locked_b,
    output logic [7:0] retry_count,
    output logic       lock_fault
);

    typedef enum logic [2:0] {
        ST_POWERDOWN    = 3'd0,
        ST_LOCK_WAIT    = 3'd1,
        ST_MCGB_RELEASE = 3'd2,
`ifdef PLL_SEQ_RETRY_EN
        ST_LOCKED       = 3'd3
`else
        ST_LOCKED       = 3'd3,
        ST_FAULT        = 3'd4
`endif
    } state_e;

    localparam logic [CNT_W-1:0] PD_LAST     = CNT_W'(PD_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MCGB_LAST   = CNT_W'(MCGB_DELAY - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [7:0]       retry_q, retry_d;
    logic             sync1_q, lk_s_q;
    logic             pd_q, mcgb_q, locked_q;
    logic             req;

    assign req = pll_powerdown_a | pll_powerdown_b;

    // Two-flop lock synchronizer, held clear while the PLL is powered down
    always_ff @(posedge clk) begin
        if (!reset_n || pd_q) begin
            sync1_q <= 1'b0;
            lk_s_q  <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            lk_s_q  <= sync1_q;
        end
    end

    // Next-state, counter and retry logic; requests take priority everywhere but FAULT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        case (state_q)
            ST_POWERDOWN: begin
                if (cnt_q != PD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!req) begin
                    state_d = ST_LOCK_WAIT;
                end
            end
            ST_LOCK_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                cnt_d = lk_s_q ? cnt_q + 1'b1 : '0;
                if (req) begin
                    state_d = ST_POWERDOWN;
                end else if (lk_s_q && cnt_q == STABLE_LAST) begin
                    state_d = ST_MCGB_RELEASE;
                end else if (tmo_q == TMO_LAST) begin
`ifdef PLL_SEQ_RETRY_EN
                    state_d = ST_POWERDOWN;
                    if (retry_q != 8'hFF) begin
                        retry_d = retry_q + 8'd1;
                    end
`else
                    state_d = ST_FAULT;
`endif
                end
            end
            ST_MCGB_RELEASE: begin
                cnt_d = cnt_q + 1'b1;
                if (req) begin
                    state_d = ST_POWERDOWN;
                end else if (!lk_s_q) begin
                    state_d = ST_LOCK_WAIT;
                end else if (cnt_q == MCGB_LAST) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (req) begin
                    state_d = ST_POWERDOWN;
                end else if (!lk_s_q) begin
                    state_d = ST_LOCK_WAIT;
                end
            end
`ifndef PLL_SEQ_RETRY_EN
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
`endif
            default: begin
                state_d = ST_POWERDOWN;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
            tmo_d = '0;
        end
    end

`ifdef PLL_SEQ_RETRY_EN
    logic fault_d;
    assign fault_d    = 1'b0;
    assign lock_fault = 1'b0;
`else
    logic fault_d, fault_q;
    assign fault_d    = (state_d == ST_FAULT);
    assign lock_fault = fault_q;

    // Fault flag registered alongside the state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`endif

    // State register with outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_POWERDOWN;
            cnt_q    <= '0;
            tmo_q    <= '0;
            retry_q  <= 8'd0;
            pd_q     <= 1'b1;
            mcgb_q   <= 1'b1;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            retry_q  <= retry_d;
            pd_q     <= (state_d == ST_POWERDOWN) | fault_d;
            mcgb_q   <= (state_d == ST_POWERDOWN)
                      | (state_d == ST_LOCK_WAIT) | fault_d;
            locked_q <= (state_d == ST_LOCKED);
        end
    end

    assign pll_powerdown     = pd_q;
    assign mcgb_rst          = mcgb_q;
    assign pll_locked_output = locked_q;
    assign pll_locked_a      = locked_q;
    assign pll_locked_b      = locked_q;
    assign retry_count       = retry_q;

endmodule

// File: tb/tb_q_sys_pll_reset_sequencer.sv
// Directed bench for q_sys_pll_reset_sequencer.
// Output vector packs {pll_powerdown, mcgb_rst, lock_out, lock_a, lock_b}.
module tb_q_sys_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b1;
    logic       pd_a = 1'b0;
    logic       pd_b = 1'b0;
    logic       pll_powerdown, mcgb_rst;
    logic       lk_o, lk_a, lk_b, lock_fault;
    logic [7:0] retry_count;
    int         checks = 0;
    int         failures = 0;

    localparam logic [7:0] V_PD   = 8'h18;
    localparam logic [7:0] V_LW   = 8'h08;
    localparam logic [7:0] V_REL  = 8'h00;
    localparam logic [7:0] V_LOCK = 8'h07;

    q_sys_pll_reset_sequencer #(
        .PD_HOLD_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .MCGB_DELAY(3),
        .LOCK_TIMEOUT(64),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pll_locked(pll_locked),
        .pll_powerdown_a(pd_a),
        .pll_powerdown_b(pd_b),
        .pll_powerdown(pll_powerdown),
        .mcgb_rst(mcgb_rst),
        .pll_locked_output(lk_o),
        .pll_locked_a(lk_a),
        .pll_locked_b(lk_b),
        .retry_count(retry_count),
        .lock_fault(lock_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] vec();
        return {3'b000, pll_powerdown, mcgb_rst, lk_o, lk_a, lk_b};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset, last reset edge is E
        step(3);
        chk("reset_vec", vec(), V_PD);
        chk("reset_retry", retry_count, 8'd0);
        chk("reset_fault", {7'd0, lock_fault}, 8'd0);
        reset_n = 1'b1;
        step(3);
        chk("pd_hold_e3", vec(), V_PD);
        step(1);
        chk("pd_fall_e4", vec(), V_LW);
        step(9);
        chk("mcgb_e13", vec(), V_LW);
        step(1);
        chk("mcgb_fall_e14", vec(), V_REL);
        step(2);
        chk("lock_e16", vec(), V_REL);
        step(1);
        chk("lock_rise_e17", vec(), V_LOCK);

        // consumer B request for 10 cycles
        pd_b = 1'b1;
        step(1);
        chk("reqb_rise", vec(), V_PD);
        step(9);
        chk("reqb_hold", vec(), V_PD);
        pd_b = 1'b0;
        step(1);
        chk("reqb_release", vec(), V_LW);
        step(9);
        chk("relock_mcgb_hold", vec(), V_LW);
        step(1);
        chk("relock_mcgb_fall", vec(), V_REL);
        step(2);
        chk("relock_pre", vec(), V_REL);
        step(1);
        chk("relock_lock", vec(), V_LOCK);

        // 1-cycle request still gets the full powerdown hold
        pd_a = 1'b1;
        step(1);
        chk("short_req_rise", vec(), V_PD);
        pd_a = 1'b0;
        step(3);
        chk("short_req_hold", vec(), V_PD);
        step(1);
        chk("short_req_release", vec(), V_LW);

        // request collides with lock-stable completion
        step(9);
        chk("collide_pre", vec(), V_LW);
        pd_a = 1'b1;
        step(1);
        chk("collide_req_wins", vec(), V_PD);
        pd_a = 1'b0;
        step(1);
        chk("collide_after", vec(), V_PD);
        step(3);
        chk("collide_release", vec(), V_LW);
        step(12);
        chk("collide_relock_pre", vec(), V_REL);
        step(1);
        chk("collide_relock", vec(), V_LOCK);

        // loss of lock: outputs drop 3 edges after raw lock falls
        pll_locked = 1'b0;
        step(2);
        chk("lol_e2", vec(), V_LOCK);
        step(1);
        chk("lol_e3", vec(), V_LW);
        pll_locked = 1'b1;
        step(9);
        chk("lol_relock_hold", vec(), V_LW);
        step(1);
        chk("lol_relock_mcgb", vec(), V_REL);
        step(3);
        chk("lol_relock_lock", vec(), V_LOCK);

        // 1-cycle reset while locked
        reset_n = 1'b0;
        step(1);
        chk("midreset_vec", vec(), V_PD);
        chk("midreset_retry", retry_count, 8'd0);
        chk("midreset_fault", {7'd0, lock_fault}, 8'd0);
        reset_n = 1'b1;
        step(3);
        chk("midreset_hold", vec(), V_PD);
        step(1);
        chk("midreset_release", vec(), V_LW);

        // glitching lock in LOCK_WAIT until timeout
        for (int i = 0; i < 63; i++) begin
            pll_locked = (i % 6 != 5);
            step(1);
            chk("glitch_wait", vec(), V_LW);
        end
        pll_locked = 1'b0;
        step(1);
`ifdef PLL_SEQ_RETRY_EN
        chk("tmo_retry_vec", vec(), V_PD);
        chk("tmo_retry_count", retry_count, 8'd1);
        chk("tmo_retry_fault", {7'd0, lock_fault}, 8'd0);
        step(3);
        chk("tmo_retry_hold", vec(), V_PD);
        step(1);
        chk("tmo_retry_release", vec(), V_LW);
`else
        chk("tmo_fault_vec", vec(), V_PD);
        chk("tmo_fault_flag", {7'd0, lock_fault}, 8'd1);
        chk("tmo_fault_retry", retry_count, 8'd0);
        pd_a = 1'b1;
        step(2);
        chk("fault_req_a", vec(), V_PD);
        pd_a = 1'b0;
        pd_b = 1'b1;
        step(2);
        chk("fault_req_b", vec(), V_PD);
        pd_b = 1'b0;
        pll_locked = 1'b1;
        step(20);
        chk("fault_sticky_vec", vec(), V_PD);
        chk("fault_sticky_flag", {7'd0, lock_fault}, 8'd1);
        reset_n = 1'b0;
        step(1);
        chk("fault_clear_vec", vec(), V_PD);
        chk("fault_clear_flag", {7'd0, lock_fault}, 8'd0);
        reset_n = 1'b1;
        step(2);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/q_sys_pll_reset_sequencer.md
# q_sys_pll_reset_sequencer

Single-clock sequencer for one transceiver PLL and its master clock-generation block (MCGB). It merges the powerdown requests from two consumers (A and B) and drives PLL powerdown and MCGB reset in the required order. It qualifies the raw `pll_locked` with a synchronizer, stability filter and lock timeout, and fans the qualified lock back to both consumers. It sits between the PLL/MCGB and the per-channel reset controllers in `q_sys`.

## Interface
Parameters:
- `PD_HOLD_CYCLES`, 16: minimum cycles `pll_powerdown` stays asserted per entry; range ≥1.
- `LOCK_STABLE_CYCLES`, 32: consecutive synchronized-high cycles of `pll_locked` required; range ≥1.
- `MCGB_DELAY`, 8: cycles between `mcgb_rst` deassertion and lock reporting; range ≥1.
- `LOCK_TIMEOUT`, 4096: cycles allowed in LOCK_WAIT; must be > `LOCK_STABLE_CYCLES`.
- `CNT_W`, 16: width of the shared state counter and timeout counter; must hold every parameter value.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `pll_locked` in 1: raw PLL lock, asynchronous to `clk`.
- `pll_powerdown_a` in 1: powerdown request from consumer A, synchronous to `clk`.
- `pll_powerdown_b` in 1: powerdown request from consumer B, synchronous to `clk`.
- `pll_powerdown` out 1: PLL powerdown.
- `mcgb_rst` out 1: MCGB reset.
- `pll_locked_output` out 1: qualified lock.
- `pll_locked_a` out 1: qualified lock to consumer A; identical to `pll_locked_output`.
- `pll_locked_b` out 1: qualified lock to consumer B; identical to `pll_locked_output`.
- `retry_count` out 8: number of lock timeouts, saturating at 255.
- `lock_fault` out 1: lock timeout fault.

## Operation
- `pll_locked` passes through a 2-flop synchronizer; `lk_s` denotes its output. Requests are used directly: `req = pll_powerdown_a | pll_powerdown_b`.
- States:
  - POWERDOWN: `pll_powerdown` = 1, `mcgb_rst` = 1. The counter increments and saturates at `PD_HOLD_CYCLES - 1`. Exit to LOCK_WAIT when the counter is saturated and `req` = 0.
  - LOCK_WAIT: `pll_powerdown` = 0, `mcgb_rst` = 1.
    - The stable counter increments while `lk_s` = 1 and clears to 0 on any `lk_s` = 0.
    - The timeout counter increments every cycle from state entry and is not cleared by lock glitches.
    - Exit to MCGB_RELEASE when the stable counter reaches `LOCK_STABLE_CYCLES - 1` with `lk_s` = 1.
    - Timeout when the timeout counter reaches `LOCK_TIMEOUT - 1`; behaviour per Configuration.
  - MCGB_RELEASE: `pll_powerdown` = 0, `mcgb_rst` = 0. The counter runs to `MCGB_DELAY - 1`, then the state moves to LOCKED. An `lk_s` = 0 in this state sends the block back to LOCK_WAIT.
  - LOCKED: `mcgb_rst` = 0; all three lock outputs = 1. An `lk_s` = 0 sends the block to LOCK_WAIT, with `mcgb_rst` reasserted and the lock outputs dropping on the same edge.
  - FAULT (macro absent only): `pll_powerdown` = 1, `mcgb_rst` = 1, `lock_fault` = 1. Exit only via `reset_n`.
- Priority:
  - `req` = 1 in LOCK_WAIT, MCGB_RELEASE or LOCKED forces POWERDOWN with the counter cleared.
  - `req` beats a simultaneous lock-stable completion, timeout or lock loss.
  - `req` is ignored in FAULT.
- Every state entry clears both counters.
- Lock outputs are 1 only in LOCKED.

## Timing
- All outputs are registered and change on the same edge as the state register.
- Reset values: `pll_powerdown` = 1, `mcgb_rst` = 1, all lock outputs 0, `retry_count` = 0, `lock_fault` = 0. The state resets to POWERDOWN with counters at 0.
- If reset is released at edge E and `req` = 0, `pll_powerdown` falls at edge E + `PD_HOLD_CYCLES`.
- From the edge where `lk_s` first rises and stays high:
  - `mcgb_rst` falls `LOCK_STABLE_CYCLES` edges later.
  - The lock outputs rise a further `MCGB_DELAY` edges later.
  - Add 2 edges of synchronizer latency, measured from raw `pll_locked`.
- Loss of lock: the lock outputs fall 3 edges after raw `pll_locked` falls (2 edges of synchronizer, 1 edge of state update).
- Request response: `pll_powerdown` rises 1 edge after `req` rises. `req` held for N ≥ `PD_HOLD_CYCLES` cycles keeps powerdown asserted until 1 edge after `req` falls.
- `reset_n` low mid-sequence returns every output to its reset value on the next edge.

## Configuration
- `PLL_SEQ_RETRY_EN` defined:
  - A LOCK_WAIT timeout moves the block to POWERDOWN and increments `retry_count`, saturating at 255.
  - `lock_fault` is tied to 0 and FAULT is not built.
- `PLL_SEQ_RETRY_EN` undefined:
  - A LOCK_WAIT timeout moves the block to FAULT.
  - `retry_count` stays 0.

## Test plan
All scenarios use PD=4, STABLE=8, MCGB=3, TIMEOUT=64.
- Reset release with `pll_locked` = 1 constant, `req` = 0 → `pll_powerdown` falls at edge 4; `mcgb_rst` falls at edge 14 (4 + 2 sync + 8); lock outputs rise at edge 17.
- In LOCKED, raise `pll_powerdown_b` for 10 cycles → `pll_powerdown` = 1 from the next edge until 1 edge after the request drops. Lock outputs fall with `pll_powerdown` rising; full relock sequence follows.
- `pll_locked` pulses low for 1 cycle every 6 cycles during LOCK_WAIT → stable counter keeps restarting and `mcgb_rst` never falls. With the macro defined: timeout at cycle 64, `retry_count` = 1, powerdown reasserted for 4 cycles.
- Same as scenario 3 without the macro → `lock_fault` = 1 at timeout. Outputs stay at `pll_powerdown` = 1 and `mcgb_rst` = 1 despite any `req` toggling, until `reset_n` = 0.
- `req` rises on the same edge the lock-stable count completes → POWERDOWN is entered and `mcgb_rst` stays 1.
- `reset_n` asserted for 1 cycle while in LOCKED → all outputs return to their reset values on the next edge and the sequence restarts from POWERDOWN.
